kf_predict_unit: RTL
====================

Name: kf_predict_unit

Overview:
- Time-update (predict) stage of the 6-state constant-velocity Kalman filter. State order is pos x,y,z then vel x,y,z.
- Computes x' = F·x and P' = F·P·Fᵀ + Q, with F = [[I, dt·I],[0, I]].
- Sequential, single shared multiplier, start/done handshake.
- Produces the 16-bit signed fixed-point X/P set consumed by the measurement-update stage, and takes that stage's results (re-quantised) back as inputs.

Parameters:
- W, 16, data width; signed two's-complement.
- FRAC, 8, fraction bits (Q8.8).
- DT, 16'sd26, timestep in Q8.8 (≈0.1016).
- Q_POS, 16'sd0, process noise added to P'[i][i], i=0..2.
- Q_VEL, 16'sd0, process noise added to P'[i][i], i=3..5.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only in IDLE
- x_in  in  6*W  state; element i at [i*W +: W]
- p_in  in  36*W  covariance, row-major; element r*6+c at [(r*6+c)*W +: W]
- busy  out  1  high while computing
- done  out  1  one-cycle pulse; outputs valid
- x_out  out  6*W  predicted state, same packing
- p_out  out  36*W  predicted covariance, same packing

Behaviour:
- Reset: asynchronous on rst_n low. busy=0, done=0, x_out=0, p_out=0, FSM=IDLE, internal regs cleared. Reset mid-operation aborts the computation; no done pulse follows.
- FSM: IDLE → CAPTURE → XPRED → FP → PFT → ADDQ → DONE → IDLE.
- IDLE: start=1 at an edge registers x_in/p_in into working regs and moves to CAPTURE. start is ignored in every other state; no queueing.
- CAPTURE (1 cycle): busy=1.
- XPRED (3 cycles, i=0..2): x'[i] = sat(x[i] + ((DT·x[i+3]) >>> FRAC)). x'[3..5] = x[3..5].
- FP (18 cycles, rows i=0..2, cols j=0..5, j fastest): A[i][j] = sat(P[i][j] + ((DT·P[i+3][j]) >>> FRAC)). Rows 3..5: A = P, copied with no cycles spent.
- PFT (18 cycles, rows r=0..5, cols c=0..2, c fastest): P'[r][c] = sat(A[r][c] + ((DT·A[r][c+3]) >>> FRAC)). P'[r][c+3] = A[r][c+3].
- ADDQ (1 cycle): diagonal elements get +Q_POS (0..2) or +Q_VEL (3..5), all six in parallel with saturation. x_out/p_out registered from working regs on this edge.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE.
- Latency: start accepted at edge 0 → done high during cycle 42 (1+3+18+18+1+1). Fixed, data-independent.
- busy is high in CAPTURE through ADDQ. x_out/p_out hold their value until the next ADDQ.
- Arithmetic:
  - Product is 2W-bit signed.
  - Arithmetic right shift by FRAC, truncating toward −∞.
  - Sum formed in W+2 bits, then saturated to [−2^(W−1), 2^(W−1)−1].
  - Intermediates A and P' are stored saturated at W bits.
- Symmetry of P' is not enforced; the output follows P as given.

Decomposition:
- Shared package kf_pkg:
  - localparams N=6, W, FRAC.
  - FSM state enum.
  - Function sat_w (W+2 → W).
  - Index helpers for flat packing.
- The measurement-update stage imports the same package.
- One natural sub-module, kf_mac_sat: inputs a, b, c; output sat(c + ((a·b) >>> FRAC)). Purely combinational, instanced once and time-shared by XPRED, FP and PFT.

Test Plan:
- Nominal: Q=0, x_in pos0=256, vel0=512, others 0; P=I·256 → x_out[0]=308, x_out[3]=512; P'[0][0]=258, P'[0][3]=26, P'[3][0]=26, P'[3][3]=256, P'[1][1]=258. done at cycle 42 exactly.
- Process noise: Q_POS=3, Q_VEL=4, same inputs → P'[0][0]=261, P'[3][3]=260, off-diagonal elements unchanged.
- Saturation: pos0=32767, vel0=32767 → x_out[0]=32767. pos1=−32768, vel1=−32768 → x_out[1]=−32768.
- Rounding: pos0=0, vel0=−1 → x_out[0]=−1 (floor). vel0=+1 → x_out[0]=0.
- Handshake: start held high across a whole run → exactly one done per accepted start. Start pulsed while busy → ignored; busy, latency and outputs unaffected.
- Reset mid-run: rst_n low at cycle 20 → outputs 0 immediately, busy=0, no done. After release, a fresh start gives the correct result at +42.

Source files
------------

// File: rtl/kf_pkg.sv
// Shared types and helpers for the Kalman filter predict and update stages.
// Q8.8 signed fixed point, 6-state constant-velocity model.
package kf_pkg;

  localparam int N    = 6;
  localparam int W    = 16;
  localparam int FRAC = 8;

  typedef logic signed [W+1:0] ext_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_XPRED,
    S_FP,
    S_PFT,
    S_ADDQ,
    S_DONE
  } kf_state_e;

  function automatic logic signed [W-1:0] sat_w(input ext_t v);
    if (v[W+1:W-1] == 3'b000 || v[W+1:W-1] == 3'b111)
      return v[W-1:0];
    else if (v[W+1])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
  endfunction

  function automatic logic signed [W-1:0] add_sat(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    ext_t s;
    s = ext_t'(a) + ext_t'(b);
    return sat_w(s);
  endfunction

  // Row-major index into the flattened 6x6 covariance.
  function automatic logic [5:0] pidx(input logic [2:0] r, input logic [2:0] c);
    return 6'(r) * 6'd6 + 6'(c);
  endfunction

endpackage

// File: rtl/kf_predict_unit_if.sv
// Start/done handshake and flat-packed X/P buses of the predict stage.
interface kf_predict_unit_if;
  import kf_pkg::*;

  logic               start;
  logic [N*W-1:0]     x_in;
  logic [N*N*W-1:0]   p_in;
  logic               busy;
  logic               done;
  logic [N*W-1:0]     x_out;
  logic [N*N*W-1:0]   p_out;

  modport master (output start, x_in, p_in, input busy, done, x_out, p_out);
  modport slave  (input start, x_in, p_in, output busy, done, x_out, p_out);
endinterface

// File: rtl/kf_mac_sat.sv
// y = sat(c + ((a*b) >>> FRAC)); the single multiplier shared by every predict step.
module kf_mac_sat
  import kf_pkg::*;
(
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  output logic signed [W-1:0] y
);

  logic signed [2*W-1:0] prod;
  ext_t                  shifted;
  ext_t                  sum;

  assign prod    = a * b;
  // Arithmetic shift floors toward -inf; W+2 bits hold any DT*x/2^FRAC for small DT.
  assign shifted = ext_t'(prod >>> FRAC);
  assign sum     = ext_t'(c) + shifted;
  assign y       = sat_w(sum);

endmodule

// File: rtl/kf_predict_unit.sv
// Kalman predict stage: x' = F*x, P' = F*P*F^T + Q with F = [[I, dt*I],[0, I]].
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for start, x_in/p_in captured on accept
// S_CAPTURE | one settle cycle, busy asserted
// S_XPRED   | x[i] += dt*x[i+3], i=0..2
// S_FP      | A = F*P, rows 0..2 updated in place
// S_PFT     | P' = A*F^T, cols 0..2 updated in place
// S_ADDQ    | diagonal += Q, outputs registered
// S_DONE    | done pulse, back to idle
module kf_predict_unit
  import kf_pkg::*;
#(
  parameter logic signed [W-1:0] DT    = 16'sd26,
  parameter logic signed [W-1:0] Q_POS = 16'sd0,
  parameter logic signed [W-1:0] Q_VEL = 16'sd0
) (
  input logic              clk,
  input logic              rst_n,
  kf_predict_unit_if.slave bus
);

  kf_state_e           state;
  logic [2:0]          row;
  logic [2:0]          col;
  logic signed [W-1:0] x_w [N];
  logic signed [W-1:0] p_w [N*N];
  logic                busy_q;
  logic                done_q;
  logic [N*W-1:0]      x_out_q;
  logic [N*N*W-1:0]    p_out_q;
  logic signed [W-1:0] mac_b;
  logic signed [W-1:0] mac_c;
  logic signed [W-1:0] mac_y;

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.x_out = x_out_q;
  assign bus.p_out = p_out_q;

  always_comb begin
    mac_b = '0;
    mac_c = '0;
    case (state)
      S_XPRED: begin
        mac_c = x_w[col];
        mac_b = x_w[col + 3'd3];
      end
      S_FP: begin
        mac_c = p_w[pidx(row, col)];
        mac_b = p_w[pidx(row + 3'd3, col)];
      end
      S_PFT: begin
        mac_c = p_w[pidx(row, col)];
        mac_b = p_w[pidx(row, col + 3'd3)];
      end
      default: ;
    endcase
  end

  kf_mac_sat u_mac (
    .a (DT),
    .b (mac_b),
    .c (mac_c),
    .y (mac_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_out_q <= '0;
      p_out_q <= '0;
      for (int i = 0; i < N; i++)   x_w[i] <= '0;
      for (int k = 0; k < N*N; k++) p_w[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            for (int i = 0; i < N; i++)   x_w[i] <= bus.x_in[i*W +: W];
            for (int k = 0; k < N*N; k++) p_w[k] <= bus.p_in[k*W +: W];
            busy_q <= 1'b1;
            row    <= '0;
            col    <= '0;
            state  <= S_CAPTURE;
          end
        end
        S_CAPTURE: state <= S_XPRED;
        S_XPRED: begin
          x_w[col] <= mac_y;
          if (col == 3'd2) begin
            col   <= '0;
            state <= S_FP;
          end else begin
            col <= col + 3'd1;
          end
        end
        S_FP: begin
          p_w[pidx(row, col)] <= mac_y;
          if (col == 3'd5) begin
            col <= '0;
            if (row == 3'd2) begin
              row   <= '0;
              state <= S_PFT;
            end else begin
              row <= row + 3'd1;
            end
          end else begin
            col <= col + 3'd1;
          end
        end
        S_PFT: begin
          p_w[pidx(row, col)] <= mac_y;
          if (col == 3'd2) begin
            col <= '0;
            if (row == 3'd5) begin
              row   <= '0;
              state <= S_ADDQ;
            end else begin
              row <= row + 3'd1;
            end
          end else begin
            col <= col + 3'd1;
          end
        end
        S_ADDQ: begin
          for (int i = 0; i < N; i++)   x_out_q[i*W +: W] <= x_w[i];
          for (int k = 0; k < N*N; k++) p_out_q[k*W +: W] <= p_w[k];
          // Diagonal writes follow the bulk copy so they take precedence.
          for (int d = 0; d < N; d++)
            p_out_q[(d*N+d)*W +: W] <= add_sat(p_w[d*N+d], (d < 3) ? Q_POS : Q_VEL);
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
